// File: rtl/simple_loader.sv
// simple_loader: UART program loader for the simple processor's instruction memory.
// Receives 8N1 bytes (LSB first) on rx, reads a big-endian 16-bit word count N,
// then N big-endian words, writing them to consecutive addresses from 0. The
// processor is held (cpu_hold) for the whole load and until load_req drops.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   rx        UART serial input, idle high, asynchronous to clk
//   load_req  level: 1 = perform a load, 0 = return to idle / abort
//   mem_wren  one-cycle instruction-memory write strobe
//   mem_addr  write address
//   mem_data  write data
//   cpu_hold  1 while not idle
//   done      load finished successfully
//   err       load failed (framing error or oversize length)
//   word_cnt  words written in the current/last load
module simple_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              load_req,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_DONE, S_ERR
  } state_t;

  logic             rx_p0, rx_p1, rx_p2;
  ustate_t          u_state, u_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             byte_valid, frame_err;
  logic             half_end, bit_end;

  state_t           state, state_next;
  logic [7:0]       len_hi;
  logic [15:0]      len;
  logic [15:0]      len_rx;

  assign half_end = (cnt == HALF_END);
  assign bit_end  = (cnt == BIT_END);
  assign len_rx   = {len_hi, shift};

  // ---- UART receiver: next-state ----
  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE:  if (rx_p2 && !rx_p1) u_next = U_START;
      // A start bit that is high again at mid-bit is a glitch.
      U_START: if (half_end) u_next = rx_p1 ? U_IDLE : U_DATA;
      U_DATA:  if (bit_end && (bit_idx == 3'd7)) u_next = U_STOP;
      U_STOP:  if (bit_end) u_next = U_IDLE;
      default: u_next = U_IDLE;
    endcase
  end

  // ---- UART receiver: synchronizer (p0/p1), edge history (p2), control ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      rx_p2      <= 1'b1;
      u_state    <= U_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_p1      <= rx_p0;
      rx_p2      <= rx_p1;
      u_state    <= u_next;
      byte_valid <= (u_state == U_STOP) && bit_end && rx_p1;
      frame_err  <= (u_state == U_STOP) && bit_end && !rx_p1;
      // Counter restarts at each sample point so later samples land mid-bit.
      if ((u_state == U_IDLE) || ((u_state == U_START) && half_end) ||
          ((u_state != U_START) && bit_end))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);
      if (u_state != U_DATA)
        bit_idx <= '0;
      else if (bit_end)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // Shift register holds the received byte until the next frame's data bits.
  always_ff @(posedge clk) begin
    if ((u_state == U_DATA) && bit_end)
      shift <= {rx_p1, shift[7:1]};
  end

  // ---- Loader FSM: next-state ----
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (load_req) state_next = S_LEN_HI;
      S_LEN_HI:  if (byte_valid) state_next = S_LEN_LO;
      S_LEN_LO:
        if (byte_valid) begin
          if (len_rx == 16'd0)
            state_next = S_DONE;
          else if ({1'b0, len_rx} > MAX_WORDS)
            state_next = S_ERR;
          else
            state_next = S_DATA_HI;
        end
      S_DATA_HI: if (byte_valid) state_next = S_DATA_LO;
      S_DATA_LO: if (byte_valid) state_next = S_WRITE;
      S_WRITE:   state_next = ((word_cnt + 16'd1) == len) ? S_DONE : S_DATA_HI;
      S_DONE:    state_next = S_DONE;
      S_ERR:     state_next = S_ERR;
      default:   state_next = S_IDLE;
    endcase
    if (frame_err && (state != S_IDLE) && (state != S_DONE) && (state != S_ERR))
      state_next = S_ERR;
    // Abort has priority over everything, including a simultaneous frame error.
    if ((state != S_IDLE) && !load_req)
      state_next = S_IDLE;
  end

  always_comb begin
    mem_wren = (state == S_WRITE);
    cpu_hold = (state != S_IDLE);
    done     = (state == S_DONE);
    err      = (state == S_ERR);
  end

  // ---- Loader FSM: state and write-port registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      mem_addr <= '0;
      mem_data <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE:
          if (load_req) begin
            mem_addr <= '0;
            word_cnt <= '0;
          end
        S_DATA_HI: if (byte_valid) mem_data[15:8] <= shift;
        S_DATA_LO: if (byte_valid) mem_data[7:0]  <= shift;
        S_WRITE: begin
          // May wrap to 0 after the last word of a full-depth image; no write follows.
          mem_addr <= mem_addr + ADDR_W'(1);
          word_cnt <= word_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // Length bytes are held without reset; they are only read after being loaded.
  always_ff @(posedge clk) begin
    if ((state == S_LEN_HI) && byte_valid) len_hi <= shift;
    if ((state == S_LEN_LO) && byte_valid) len    <= len_rx;
  end

endmodule

// File: doc/simple_loader.md
Name: simple_loader

Overview:
- Upstream program loader for the simple processor's instruction memory.
- Receives a program image over a UART serial line (8N1, LSB first) and assembles big-endian 16-bit words.
- Writes each word to consecutive instruction-memory addresses from 0, through the memory's write port.
- Asserts cpu_hold while loading so the processor's phase sequencer stays in its initial state until the image is in place.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); minimum 4.
- ADDR_W, 12, instruction-memory address width; depth = 2^ADDR_W words.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active low
- rx  input  1  UART serial input, idle high, asynchronous to clk
- load_req  input  1  level request: 1 = accept/perform a load, 0 = return to idle
- mem_wren  output  1  one-cycle write strobe to instruction memory
- mem_addr  output  ADDR_W  write address
- mem_data  output  16  write data
- cpu_hold  output  1  1 while busy; keeps the processor out of execution
- done  output  1  load completed successfully
- err  output  1  load failed (framing error or oversize length)
- word_cnt  output  16  words written in the current/last load

Behaviour:
- Reset (rst=0, any time, including mid-load) sets the following immediately:
  - mem_wren=0, mem_addr=0, mem_data=0, cpu_hold=0, done=0, err=0, word_cnt=0.
  - UART receiver to idle, loader FSM to IDLE.
- rx passes through a 2-flop synchronizer; all decoding uses the synchronized value.
- UART receiver:
  - Idle: a falling edge on the synchronized rx starts a bit counter.
  - At CLKS_PER_BIT/2 (integer) the start bit is re-sampled. If rx is high it is a glitch: return to idle with no byte.
  - Data bits are then sampled every CLKS_PER_BIT cycles, LSB first, followed by the stop bit.
  - Stop=1 gives a one-cycle byte_valid carrying the byte.
  - Stop=0 gives a one-cycle frame_err and no byte.
  - The receiver re-arms for the next start edge the cycle after the stop sample.
- Stream format: LEN_HI, LEN_LO (N = word count), then 2N bytes, each word high byte first.
- Loader FSM states: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR.
- IDLE:
  - cpu_hold=0, done=0, err=0.
  - load_req=1 → LEN_HI; word_cnt←0, mem_addr←0.
  - Bytes received while in IDLE are discarded.
- LEN_HI → LEN_LO on byte.
- On the LEN_LO byte:
  - N=0 → DONE.
  - N>2^ADDR_W → ERR.
  - Otherwise → DATA_HI.
- DATA_HI → DATA_LO on byte (latched as mem_data[15:8]).
- On the DATA_LO byte: mem_data[7:0] latched → WRITE.
- WRITE (exactly one cycle):
  - mem_wren=1, with mem_addr and mem_data stable.
  - Next cycle: mem_addr+1, word_cnt+1.
  - word_cnt reaches N → DONE, else → DATA_HI.
  - The final increment of mem_addr may wrap to 0 when N=2^ADDR_W; no write follows, so this is harmless.
- Byte-to-write latency: mem_wren is asserted the cycle after byte_valid of the low byte.
- cpu_hold=1 in every state except IDLE. It is also held in DONE and ERR so the processor stays held until load_req is released.
- DONE: done=1; stays until load_req=0 → IDLE.
- ERR: err=1; entered on frame_err in any non-IDLE, non-terminal state. No further writes. Stays until load_req=0 → IDLE.
- load_req=0 in any loading state aborts to IDLE next cycle:
  - A pending partial word is dropped, with no write.
  - mem_wren is never asserted after the abort cycle.
  - word_cnt keeps its value.
- frame_err and load_req=0 in the same cycle: abort wins (→ IDLE).
- mem_wren is never asserted outside WRITE.

Test Plan:
- Reset/idle: rst low then high, rx=1, load_req=0 for 1000 cycles → all outputs 0, mem_wren never 1.
- Normal load (CLKS_PER_BIT=8): load_req=1, bytes 00 02 12 34 AB CD → exactly two writes, addr0=0x1234 then addr1=0xABCD. Each mem_wren is 1 cycle wide. Then done=1, word_cnt=2, cpu_hold=1. Drop load_req → cpu_hold=0, done=0 next cycle.
- Zero length / glitch: bytes 00 00 → done=1, no writes. Separately, a 2-cycle low pulse on rx → no byte, FSM unchanged.
- Framing error: 00 01 12, then 0x34 with stop bit 0 → err=1, no write, word_cnt=0.
- Oversize (ADDR_W=12): bytes 10 01 → ERR; load_req=0 → IDLE.
- Abort/reset mid-load: N=3, drop load_req after the first write → IDLE, one write total, word_cnt=1. Repeat and assert rst during DATA_LO → outputs 0 immediately, no write.
